prog_loader: RTL and testbench

- Writer side of the CPU's instruction-memory interface.
- Accepts a framed byte stream on a valid/ready port and writes it into program memory starting at address 0.
- Holds the CPU in reset while loading; releases it when the frame is complete, so execution starts at PC 0 on freshly written code.
- Sits between a host link (UART receiver or bench) and the CPU/prog memory write port.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/prog_loader.sv | 148 ++++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: default widths, loader state encoding,
// and program memory depth.
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int FULL_DEPTH = 1 << ADDR_W_DEF;

  typedef logic [2:0] ld_state_t;

  localparam ld_state_t ST_IDLE = 3'd0;
  localparam ld_state_t ST_HDR  = 3'd1;
  localparam ld_state_t ST_LOAD = 3'd2;
  localparam ld_state_t ST_CHK  = 3'd3;
  localparam ld_state_t ST_RUN  = 3'd4;

endpackage

// File: rtl/prog_loader.sv
// Program loader: framed byte stream into instruction memory, CPU held in
// reset until the frame lands. LOADER_CHECKSUM_EN adds a trailing XOR byte.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t       state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_nx;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] hdr_raw;
  logic [ADDR_W:0] hdr_n;
  logic            xfer;
  logic            last;

  assign xfer     = in_valid && in_ready;
  assign count_nx = count + 1'b1;
  assign last     = count_nx == len;
  assign hdr_raw  = in_data[ADDR_W:0];

  // Zero or oversize length means "fill the whole memory".
  always_comb begin
    hdr_n = hdr_raw;
    if (hdr_raw == '0 || hdr_raw > DEPTH) begin
      hdr_n = DEPTH;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      len       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HDR;
            in_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            err_q    <= 1'b0;
`endif
          end
        end
        ST_HDR: begin
          if (xfer) begin
            len   <= hdr_n;
            count <= '0;
            state <= ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= in_data;
            count     <= count_nx;
`ifdef LOADER_CHECKSUM_EN
            sum       <= sum ^ in_data;
`endif
            if (last) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= ST_CHK;
`else
              state    <= ST_RUN;
              in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
              err_q <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: begin
          if (start) begin
            state     <= ST_HDR;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
`endif
          end else if (cpu_reset) begin
            // One cycle after the final write, so it lands before fetch.
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of header lengths, directed
// corner sequences and random frames against a frame-level model.
module tb_prog_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;

  int         total = 0;
  int         bad = 0;
  logic       alt = 1'b1;
  logic [7:0] pay[$];

  typedef struct {
    logic [7:0] hdr;
    int         n;
    int         mode;
  } vec_t;

  vec_t tbl[11];

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec rule: low AW+1 bits; 0 or >DEPTH means full depth.
  function automatic int frame_len(input logic [7:0] h);
    int n;
    n = int'(h) % (2 * DEPTH);
    return (n == 0 || n > DEPTH) ? DEPTH : n;
  endfunction

  // Called at a negedge; drives one cycle and checks the write it implies.
  task automatic tick(input logic s, input logic v, input logic [7:0] d,
                      input int widx, output logic acc);
    start    = s;
    in_valid = v;
    in_data  = d;
    acc      = v && in_ready;
    @(negedge clk);
    start    = 1'b0;
    if (acc && widx >= 0) begin
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, widx);
      chk("wr_data", mem_wdata, d);
    end else begin
      chk("no_wr", mem_we, 0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int widx,
                           input int mode);
    logic a;
    logic v;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 64) begin
      case (mode)
        1: begin v = alt; alt = ~alt; end
        2: v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      tick(1'b0, v, v ? b : 8'($urandom), widx, a);
      tries++;
    end
    if (!a) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: byte %0h idx %0d not taken", b, widx);
    end
  endtask

  task automatic begin_frame();
    logic a;
    tick(1'b1, 1'b0, 8'h00, -1, a);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_ready", in_ready, 1);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n,
                            input int mode, input bit ck_ok);
    logic [7:0] x;
    logic       a;
    x = 8'h00;
    push_byte(hdr, -1, mode);
    chk("hdr_ready", in_ready, 1);
    for (int k = 0; k < n; k++) begin
      push_byte(pay[k], k, mode);
      x = x ^ pay[k];
      if (k < n - 1) chk("load_ready", in_ready, 1);
    end
    chk("last_wr_cpu_reset", cpu_reset, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("chk_ready", in_ready, 1);
    push_byte(ck_ok ? x : ~x, -1, mode);
    chk("chk_end_ready", in_ready, 0);
    if (!ck_ok) begin
      chk("ck_err", err, 1);
      chk("ck_err_done", done, 0);
      chk("ck_err_cpu_reset", cpu_reset, 1);
      tick(1'b0, 1'b1, 8'h5A, -1, a);
      chk("ck_err_hold_rst", cpu_reset, 1);
      chk("ck_err_hold_err", err, 1);
      chk("ck_err_hold_rdy", in_ready, 0);
      return;
    end
    chk("ck_ok_cpu_reset", cpu_reset, 1);
`else
    chk("end_ready", in_ready, 0);
`endif
    tick(1'b0, 1'b0, 8'h00, -1, a);
    chk("release", cpu_reset, 0);
    chk("done", done, 1);
    chk("run_ready", in_ready, 0);
    chk("run_err", err, 0);
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic a;
    logic [7:0] h;
    bit ok;

    tbl[0]  = '{8'd3,   3,  0};
    tbl[1]  = '{8'd0,   16, 2};
    tbl[2]  = '{8'd16,  16, 0};
    tbl[3]  = '{8'd17,  16, 2};
    tbl[4]  = '{8'd31,  16, 0};
    tbl[5]  = '{8'd32,  16, 2};
    tbl[6]  = '{8'd33,  1,  0};
    tbl[7]  = '{8'hFF,  16, 2};
    tbl[8]  = '{8'h45,  5,  0};
    tbl[9]  = '{8'd1,   1,  2};
    tbl[10] = '{8'd15,  15, 0};

    // Reset held two cycles, then idle with no start.
    @(negedge clk);
    check_reset_vals("rst0");
    @(negedge clk);
    check_reset_vals("rst1");
    reset = 1'b0;
    tick(1'b0, 1'b0, 8'h00, -1, a);
    check_reset_vals("idle0");
    tick(1'b0, 1'b1, 8'hEE, -1, a);
    check_reset_vals("idle_valid");

    // Basic three-byte frame, back-to-back.
    pay = '{8'hA1, 8'hB2, 8'hC3};
    begin_frame();
    send_frame(8'd3, 3, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h99, -1, a);
      chk("run_hold_ready", in_ready, 0);
      chk("run_hold_done", done, 1);
      chk("run_hold_cpu", cpu_reset, 0);
    end

    // Full depth via header 0, valid toggling every cycle.
    pay.delete();
    for (int k = 0; k < DEPTH; k++) pay.push_back(8'(k));
    alt = 1'b1;
    begin_frame();
    send_frame(8'd0, DEPTH, 1, 1'b1);

    // Header length decode table.
    for (int i = 0; i < 11; i++) begin
      fill_rand(tbl[i].n);
      begin_frame();
      send_frame(tbl[i].hdr, tbl[i].n, tbl[i].mode, 1'b1);
    end

    // Asynchronous reset in the middle of a frame.
    begin_frame();
    push_byte(8'd5, -1, 0);
    push_byte(8'h11, 0, 0);
    push_byte(8'h22, 1, 0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, 1'b1, 8'h33, -1, a);
    check_reset_vals("post_rst");
    pay = '{8'h55};
    begin_frame();
    send_frame(8'd1, 1, 0, 1'b1);

    // Re-entry from RUN.
    pay = '{8'h7E};
    begin_frame();
    send_frame(8'd1, 1, 0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    pay = '{8'h0F, 8'hF0};
    begin_frame();
    send_frame(8'd2, 2, 0, 1'b1);
    begin_frame();
    send_frame(8'd2, 2, 0, 1'b0);
    begin_frame();
    send_frame(8'd2, 2, 0, 1'b1);
`endif

    // Random frames.
    for (int i = 0; i < 40; i++) begin
      h = 8'($urandom);
      ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ok = ($urandom_range(0, 3) != 0);
`endif
      fill_rand(frame_len(h));
      begin_frame();
      send_frame(h, frame_len(h), 2, ok);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
